traffic_phase_scheduler: RTL and testbench

//  Phase sequencer/arbiter for the 4-way junction: main road (light_M1, light_M2), main turn (light_MT), side road (light_S), ped crossing.

---
 rtl/traffic_phase_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
// Phase sequencer for a four-way junction. MAIN is the resting phase; turn,
// side and pedestrian requests are latched and served one at a time in
// round-robin order. Each served phase gets one green, then yellow and
// all-red clearance, and control always returns to MAIN. All timing is in
// clk cycles.
module traffic_phase_scheduler #(
  parameter int T_MAIN_MIN = 7,
  parameter int T_TURN     = 3,
  parameter int T_SIDE     = 5,
  parameter int T_WALK     = 4,
  parameter int T_YELLOW   = 3,
  parameter int T_ALLRED   = 1,
  parameter int CW         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_turn,
  input  logic       req_side,
  input  logic       req_ped,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S,
  output logic       walk,
  output logic [2:0] pending,
  output logic [2:0] grant,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PH_MAIN = 2'd0,
    PH_TURN = 2'd1,
    PH_SIDE = 2'd2,
    PH_PED  = 2'd3
  } phase_t;

  // Lamp encoding {R,Y,G}, one-hot.
  localparam logic [2:0] LT_R = 3'b100;
  localparam logic [2:0] LT_Y = 3'b010;
  localparam logic [2:0] LT_G = 3'b001;

  // Last counter value of each interval (the interval lasts value+1 cycles).
  localparam logic [CW-1:0] C_MAIN_LAST   = CW'(T_MAIN_MIN - 1);
  localparam logic [CW-1:0] C_TURN_LAST   = CW'(T_TURN - 1);
  localparam logic [CW-1:0] C_SIDE_LAST   = CW'(T_SIDE - 1);
  localparam logic [CW-1:0] C_WALK_LAST   = CW'(T_WALK - 1);
  localparam logic [CW-1:0] C_YELLOW_LAST = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] C_ALLRED_LAST = CW'(T_ALLRED - 1);

  state_t        r_state, w_state_nxt;
  phase_t        r_phase, w_phase_nxt;
  phase_t        r_next_phase, w_next_phase_nxt;
  phase_t        r_rr, w_rr_nxt;
  phase_t        w_win;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [CW-1:0] w_green_last;
  logic [2:0]    r_pending, w_pending_nxt;
  logic [2:0]    w_clr;
  logic [2:0]    w_grant;
  logic          w_enter_green;

  // Round-robin pick: first pending request at or after the rr pointer.
  always_comb begin
    case (r_rr)
      PH_SIDE: w_win = r_pending[1] ? PH_SIDE : (r_pending[2] ? PH_PED  : PH_TURN);
      PH_PED:  w_win = r_pending[2] ? PH_PED  : (r_pending[0] ? PH_TURN : PH_SIDE);
      default: w_win = r_pending[0] ? PH_TURN : (r_pending[1] ? PH_SIDE : PH_PED);
    endcase
  end

  // Green length of the current served phase.
  always_comb begin
    case (r_phase)
      PH_TURN: w_green_last = C_TURN_LAST;
      PH_SIDE: w_green_last = C_SIDE_LAST;
      PH_PED:  w_green_last = C_WALK_LAST;
      default: w_green_last = C_MAIN_LAST;
    endcase
  end

  // Next-state logic: green/yellow/all-red sequencing and arbitration.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt      = r_state;
    w_phase_nxt      = r_phase;
    w_cnt_nxt        = r_cnt + CW'(1);
    w_next_phase_nxt = r_next_phase;
    w_rr_nxt         = r_rr;
    w_enter_green    = 1'b0;
    case (r_state)
      ST_GREEN: begin
        if (r_phase == PH_MAIN) begin
          if (r_cnt >= C_MAIN_LAST && |r_pending) begin
            w_state_nxt      = ST_YELLOW;
            w_cnt_nxt        = '0;
            w_next_phase_nxt = w_win;
            case (w_win)
              PH_TURN: w_rr_nxt = PH_SIDE;
              PH_SIDE: w_rr_nxt = PH_PED;
              default: w_rr_nxt = PH_TURN;
            endcase
          end else if (r_cnt >= C_MAIN_LAST) begin
            // Hold at the minimum so a later request preempts at once.
            w_cnt_nxt = r_cnt;
          end
        end else if (r_cnt == w_green_last) begin
          w_state_nxt = ST_YELLOW;
          w_cnt_nxt   = '0;
        end
      end
      ST_YELLOW: begin
        if (r_cnt == C_YELLOW_LAST) begin
          w_state_nxt = ST_ALLRED;
          w_cnt_nxt   = '0;
        end
      end
      ST_ALLRED: begin
        if (r_cnt == C_ALLRED_LAST) begin
          w_state_nxt = ST_GREEN;
          w_cnt_nxt   = '0;
          if (r_phase == PH_MAIN) begin
            w_phase_nxt   = r_next_phase;
            w_enter_green = 1'b1;
          end else begin
            w_phase_nxt = PH_MAIN;
          end
        end
      end
      default: begin
        w_state_nxt = ST_GREEN;
        w_phase_nxt = PH_MAIN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Request latching; the served bit clears on the edge its green begins.
  always_comb begin
    w_clr = 3'b000;
    if (w_enter_green) begin
      case (r_next_phase)
        PH_TURN: w_clr = 3'b001;
        PH_SIDE: w_clr = 3'b010;
        PH_PED:  w_clr = 3'b100;
        default: w_clr = 3'b000;
      endcase
    end
    w_pending_nxt = (r_pending | {req_ped, req_side, req_turn}) & ~w_clr;
  end

  // Grant pulse on the first green cycle of a served phase.
  always_comb begin
    w_grant = 3'b000;
    if (r_state == ST_GREEN && r_cnt == '0) begin
      case (r_phase)
        PH_TURN: w_grant = 3'b001;
        PH_SIDE: w_grant = 3'b010;
        PH_PED:  w_grant = 3'b100;
        default: w_grant = 3'b000;
      endcase
    end
  end

  // Lamp decode from state and phase; anything outside the green set is red.
  always_comb begin
    logic [2:0] w_on;
    light_M1 = LT_R;
    light_M2 = LT_R;
    light_MT = LT_R;
    light_S  = LT_R;
    walk     = 1'b0;
    w_on     = (r_state == ST_GREEN) ? LT_G : LT_Y;
    if (r_state != ST_ALLRED) begin
      case (r_phase)
        PH_MAIN: begin
          light_M1 = w_on;
          light_M2 = w_on;
        end
        PH_TURN: begin
          light_M1 = w_on;
          light_MT = w_on;
        end
        PH_SIDE: light_S = w_on;
        default: walk = (r_state == ST_GREEN);
      endcase
    end
  end

  // State registers with synchronous active-low reset; reset aborts any phase.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst) begin
      r_state      <= ST_GREEN;
      r_phase      <= PH_MAIN;
      r_cnt        <= '0;
      r_pending    <= 3'b000;
      r_rr         <= PH_TURN;
      r_next_phase <= PH_TURN;
    end else begin
      r_state      <= w_state_nxt;
      r_phase      <= w_phase_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pending    <= w_pending_nxt;
      r_rr         <= w_rr_nxt;
      r_next_phase <= w_next_phase_nxt;
    end
  end

  assign pending = r_pending;
  assign grant   = w_grant;
  assign phase   = r_phase;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler
// Directed scenarios followed by randomized requests and resets. The
// reference model expands each served phase into a queue of expected
// per-cycle output frames; an empty queue means MAIN green.
module tb_traffic_phase_scheduler;

  logic       clk;
  logic       rst;
  logic       req_turn, req_side, req_ped;
  logic [2:0] light_M1, light_M2, light_MT, light_S;
  logic       walk;
  logic [2:0] pending, grant;
  logic [1:0] phase;

  traffic_phase_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .req_turn (req_turn),
    .req_side (req_side),
    .req_ped  (req_ped),
    .light_M1 (light_M1),
    .light_M2 (light_M2),
    .light_MT (light_MT),
    .light_S  (light_S),
    .walk     (walk),
    .pending  (pending),
    .grant    (grant),
    .phase    (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0] m1, m2, mt, s;
    logic       walk;
    logic [2:0] grant;
    logic [1:0] ph;
  } frame_t;

  localparam int SEG_G = 0, SEG_Y = 1, SEG_AR = 2;
  int     t_green [4] = '{0, 3, 5, 4};
  frame_t q[$];
  int     main_age;
  logic [2:0] pend;
  int     rr;

  function automatic frame_t mk(input int ph, input int seg, input bit first);
    frame_t f;
    logic [3:0] gs;
    logic [2:0] on;
    case (ph)
      0:       gs = 4'b1100;
      1:       gs = 4'b1010;
      2:       gs = 4'b0001;
      default: gs = 4'b0000;
    endcase
    on      = (seg == SEG_G) ? 3'b001 : 3'b010;
    f.m1    = (seg != SEG_AR && gs[3]) ? on : 3'b100;
    f.m2    = (seg != SEG_AR && gs[2]) ? on : 3'b100;
    f.mt    = (seg != SEG_AR && gs[1]) ? on : 3'b100;
    f.s     = (seg != SEG_AR && gs[0]) ? on : 3'b100;
    f.walk  = (ph == 3 && seg == SEG_G);
    f.grant = (first && ph != 0) ? 3'(1 << (ph - 1)) : 3'b000;
    f.ph    = 2'(ph);
    return f;
  endfunction

  function automatic frame_t model_now();
    if (q.size() != 0) return q[0];
    return mk(0, SEG_G, 1'b0);
  endfunction

  task automatic model_edge(input logic r, input logic [2:0] rq);
    int w;
    frame_t f;
    if (!r) begin
      q.delete();
      main_age = 0;
      pend     = 3'b000;
      rr       = 0;
      return;
    end
    if (q.size() == 0) begin
      if (main_age >= 6 && pend != 3'b000) begin
        w = -1;
        for (int k = 0; k < 3; k++)
          if (w < 0 && pend[(rr + k) % 3]) w = (rr + k) % 3;
        rr = (w + 1) % 3;
        repeat (3) q.push_back(mk(0, SEG_Y, 1'b0));
        q.push_back(mk(0, SEG_AR, 1'b0));
        for (int j = 0; j < t_green[w + 1]; j++) q.push_back(mk(w + 1, SEG_G, j == 0));
        repeat (3) q.push_back(mk(w + 1, SEG_Y, 1'b0));
        q.push_back(mk(w + 1, SEG_AR, 1'b0));
      end else begin
        main_age++;
      end
    end else begin
      f = q.pop_front();
      if (q.size() == 0) main_age = 0;
    end
    pend = pend | rq;
    if (q.size() != 0) pend = pend & ~q[0].grant;
  endtask

  // ---------------- per-cycle helpers ----------------
  task automatic observe();
    frame_t e;
    @(negedge clk);
    e = model_now();
    check("light_M1", light_M1, e.m1);
    check("light_M2", light_M2, e.m2);
    check("light_MT", light_MT, e.mt);
    check("light_S",  light_S,  e.s);
    check("walk",     {2'b00, walk},  {2'b00, e.walk});
    check("grant",    grant,    e.grant);
    check("phase",    {1'b0, phase},  {1'b0, e.ph});
    check("pending",  pending,  pend);
  endtask

  task automatic drive_edge(input logic r, input logic t, input logic s, input logic p);
    rst      = r;
    req_turn = t;
    req_side = s;
    req_ped  = p;
    @(posedge clk);
    #1;
    model_edge(r, {p, s, t});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int wc;
    rst = 1'b0; req_turn = 1'b0; req_side = 1'b0; req_ped = 1'b0;
    drive_edge(1'b0, 1'b0, 1'b0, 1'b0);

    // Idle: 50 cycles of MAIN green after a one-cycle reset.
    for (int c = 0; c < 50; c++) begin
      observe();
      if (c == 0 || c == 49) begin
        check("idle_M1", light_M1, 3'b001);
        check("idle_M2", light_M2, 3'b001);
        check("idle_MT", light_MT, 3'b100);
        check("idle_S",  light_S,  3'b100);
        check("idle_grant", grant, 3'b000);
      end
      drive_edge(1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Side: pulse at cycle 2 after reset.
    observe(); drive_edge(1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 24; c++) begin
      observe();
      if (c == 6)  check("side_main_g6", light_M1, 3'b001);
      if (c == 7)  check("side_main_y7", light_M1, 3'b010);
      if (c == 10) check("side_allred10", light_M1, 3'b100);
      if (c == 11) check("side_grant11", grant, 3'b010);
      if (c == 15) check("side_g15", light_S, 3'b001);
      if (c == 16) check("side_y16", light_S, 3'b010);
      if (c == 19) check("side_allred19", light_S, 3'b100);
      if (c == 20) check("side_main_g20", light_M1, 3'b001);
      drive_edge(1'b1, 1'b0, (c == 2), 1'b0);
    end

    // Round robin: all three requests at cycle 10.
    observe(); drive_edge(1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 75; c++) begin
      observe();
      if (c == 16) check("rr_turn_grant", grant, 3'b001);
      if (c == 34) check("rr_side_grant", grant, 3'b010);
      if (c == 54) check("rr_ped_grant",  grant, 3'b100);
      if (c == 33) check("rr_main_between", {1'b0, phase}, 3'd0);
      drive_edge(1'b1, (c == 10), (c == 10), (c == 10));
    end

    // Pedestrian: walk for exactly four cycles, vehicles all red.
    observe(); drive_edge(1'b0, 1'b0, 1'b0, 1'b0);
    wc = 0;
    for (int c = 0; c < 25; c++) begin
      observe();
      if (walk) begin
        wc++;
        check("ped_vehicles_red", light_M1 & light_M2 & light_MT & light_S, 3'b100);
      end
      drive_edge(1'b1, 1'b0, 1'b0, (c == 0));
    end
    check("ped_walk_cycles", 3'(wc), 3'd4);

    // Turn: M1 and MT green, then yellow; pending[0] cleared at grant.
    observe(); drive_edge(1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 22; c++) begin
      observe();
      if (c == 10) check("turn_pending_before", pending, 3'b001);
      if (c == 11) begin
        check("turn_M1_g", light_M1, 3'b001);
        check("turn_MT_g", light_MT, 3'b001);
        check("turn_M2_r", light_M2, 3'b100);
        check("turn_S_r",  light_S,  3'b100);
        check("turn_pending_clr", pending, 3'b000);
      end
      if (c == 14) check("turn_MT_y", light_MT, 3'b010);
      if (c == 16) check("turn_M1_y", light_M1, 3'b010);
      drive_edge(1'b1, (c == 0), 1'b0, 1'b0);
    end

    // Reset mid-SIDE green with req_side held high.
    observe(); drive_edge(1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 14; c++) begin
      observe();
      if (c == 13) check("mid_side_green", light_S, 3'b001);
      drive_edge((c != 13), 1'b0, 1'b1, 1'b0);
    end
    for (int c = 0; c < 30; c++) begin
      observe();
      if (c == 0) begin
        check("rst_mid_M1", light_M1, 3'b001);
        check("rst_mid_S",  light_S,  3'b100);
        check("rst_mid_pending", pending, 3'b000);
        check("rst_mid_phase", {1'b0, phase}, 3'd0);
      end
      if (c == 11) check("rst_mid_reserve", grant, 3'b010);
      drive_edge(1'b1, 1'b0, (c < 20), 1'b0);
    end

    // Randomized requests with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      observe();
      drive_edge(($urandom_range(399) != 0), ($urandom_range(15) == 0),
                 ($urandom_range(15) == 0), ($urandom_range(15) == 0));
    end
    observe();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
